// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: forward-select encodings
// and the default register-index width.
package hazard_unit_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Forwarding source select for one ALU operand; the memory stage beats writeback.
module fwd_sel
  import hazard_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_WIDTH
) (
  input  logic [ADDR_W-1:0] rs_e,
  input  logic [ADDR_W-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic              reg_write_w,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: shadows E/M/W register usage to drive operand
// forwarding, load-use stalls, branch flushes and a load-use stall counter.
module hazard_unit #(
  parameter int unsigned REG_ADDR_WIDTH = hazard_unit_pkg::REG_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic                      use_rs1_d,
  input  logic                      use_rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic                      reg_write_d,
  input  logic                      mem_read_d,
  input  logic                      pc_src_e,
  input  logic                      mem_busy,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [CNT_WIDTH-1:0]      lu_stall_count
);

  import hazard_unit_pkg::*;

  logic [REG_ADDR_WIDTH-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic                      reg_write_e, mem_read_e, reg_write_m, reg_write_w;
  logic                      lu_hazard, lw_stall;

  always_comb begin
    lu_hazard = mem_read_e && (rd_e != '0) &&
                ((use_rs1_d && (rd_e == rs1_d)) || (use_rs2_d && (rd_e == rs2_d)));
    // A taken branch squashes the dependent instruction, so it overrides the stall.
    lw_stall  = lu_hazard && !pc_src_e;
  end

  assign stall_f = lw_stall || mem_busy;
  assign stall_d = lw_stall || mem_busy;
  assign flush_d = pc_src_e && !mem_busy;
  assign flush_e = (lw_stall || pc_src_e) && !mem_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg_write_e <= 1'b0;
      mem_read_e  <= 1'b0;
      rd_m        <= '0;
      reg_write_m <= 1'b0;
      rd_w        <= '0;
      reg_write_w <= 1'b0;
    end else if (!mem_busy) begin
      if (flush_e) begin
        rs1_e       <= '0;
        rs2_e       <= '0;
        rd_e        <= '0;
        reg_write_e <= 1'b0;
        mem_read_e  <= 1'b0;
      end else begin
        rs1_e       <= rs1_d;
        rs2_e       <= rs2_d;
        rd_e        <= rd_d;
        reg_write_e <= reg_write_d;
        mem_read_e  <= mem_read_d;
      end
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_count <= '0;
    end else if (lw_stall && !mem_busy && (lu_stall_count != '1)) begin
      lu_stall_count <= lu_stall_count + CNT_WIDTH'(1);
    end
  end

  fwd_sel #(.ADDR_W(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_e        (rs1_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .sel         (forward_a)
  );

  fwd_sel #(.ADDR_W(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_e        (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .sel         (forward_b)
  );

endmodule
